// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package rf_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int NREGS    = 32;
    localparam int LAST_REG = NREGS - 1;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NREQ = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer advances past the winner. en low forces no grant and freezes the pointer.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (en) begin
            // k walks priority order from the pointer; j selects the matching index
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    if (!found && req[j] && (j == (int'(ptr_q) + k) % N)) begin
                        grant[j] = 1'b1;
                        ptr_d    = PW'((j + 1) % N);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller: clears x1..x31 after reset, then
// arbitrates NREQ writeback sources onto the single registered write port.
module rf_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_adr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 rf_en,
    output logic [AW-1:0]        rf_w_adr,
    output logic [XLEN-1:0]      rf_w_data,
    output logic                 init_done
);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            rf_en_q, rf_en_d;
    logic [AW-1:0]   rf_w_adr_q, rf_w_adr_d;
    logic [XLEN-1:0] rf_w_data_q, rf_w_data_d;
    logic            init_done_q, init_done_d;
    logic [AW-1:0]   sel_adr;
    logic [XLEN-1:0] sel_data;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .en    (state_q == RUN),
        .grant (ack)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rf_en_d     = 1'b0;
        rf_w_adr_d  = rf_w_adr_q;
        rf_w_data_d = rf_w_data_q;
        init_done_d = init_done_q;
        sel_adr     = '0;
        sel_data    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (ack[j]) begin
                sel_adr  = req_adr[j*AW +: AW];
                sel_data = req_data[j*XLEN +: XLEN];
            end
        end
        case (state_q)
            INIT: begin
                rf_en_d     = 1'b1;
                rf_w_adr_d  = cnt_q;
                rf_w_data_d = '0;
                cnt_d       = cnt_q + AW'(1);
                if (cnt_q == AW'(LAST_REG)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                // x0 is hard-wired zero: the grant is still taken but nothing is written
                if ((|ack) && (sel_adr != '0)) begin
                    rf_en_d     = 1'b1;
                    rf_w_adr_d  = sel_adr;
                    rf_w_data_d = sel_data;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= AW'(1);
            rf_en_q     <= 1'b0;
            rf_w_adr_q  <= '0;
            rf_w_data_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rf_en_q     <= rf_en_d;
            rf_w_adr_q  <= rf_w_adr_d;
            rf_w_data_q <= rf_w_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_en     = rf_en_q;
    assign rf_w_adr  = rf_w_adr_q;
    assign rf_w_data = rf_w_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: clear sequence, arbitration table, resets.
module tb_rf_write_ctrl;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [31:0] D0 = 32'hA0A0_0007;
    localparam logic [31:0] D1 = 32'hB1B1_0008;
    localparam logic [31:0] D2 = 32'hC2C2_0009;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*AW-1:0]   req_adr = '0;
    logic [NREQ*XLEN-1:0] req_data = '0;
    logic [NREQ-1:0]      ack;
    logic                 rf_en;
    logic [AW-1:0]        rf_w_adr;
    logic [XLEN-1:0]      rf_w_data;
    logic                 init_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .ack       (ack),
        .rf_en     (rf_en),
        .rf_w_adr  (rf_w_adr),
        .rf_w_data (rf_w_data),
        .init_done (init_done)
    );

    typedef struct {
        logic [2:0]  req;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  ack;
        logic        en;
        logic        chk;
        logic [4:0]  adr;
        logic [31:0] data;
    } vec_t;

    vec_t vec[17];

    function automatic vec_t mk(logic [2:0] r, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] e_ack, logic e_en, logic chk,
                                logic [4:0] e_adr, logic [31:0] e_data);
        vec_t v;
        v.req = r; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.ack = e_ack; v.en = e_en; v.chk = chk; v.adr = e_adr; v.data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2);
        req      = r;
        req_adr  = {a2, a1, a0};
        req_data = {d2, d1, d0};
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ack"}, 32'(ack), 32'd0);
        check({tag, ".rf_en"}, 32'(rf_en), 32'd0);
        check({tag, ".rf_w_adr"}, 32'(rf_w_adr), 32'd0);
        check({tag, ".rf_w_data"}, rf_w_data, 32'd0);
        check({tag, ".init_done"}, 32'(init_done), 32'd0);
    endtask

    // Caller leaves rst deasserted before the first posedge; edge k issues x(k).
    task automatic clear_seq(input string tag, input int ncyc, input logic [2:0] ack_after);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.en[%0d]", tag, k), 32'(rf_en), (k <= 31) ? 32'd1 : 32'd0);
            check($sformatf("%s.adr[%0d]", tag, k), 32'(rf_w_adr), (k <= 31) ? 32'(k) : 32'd31);
            check($sformatf("%s.data[%0d]", tag, k), rf_w_data, 32'd0);
            check($sformatf("%s.done[%0d]", tag, k), 32'(init_done), (k >= 31) ? 32'd1 : 32'd0);
            check($sformatf("%s.ack[%0d]", tag, k), 32'(ack), (k >= 31) ? 32'(ack_after) : 32'd0);
        end
    endtask

    initial begin
        vec[0]  = mk(3'b010, 7, 5, 9, D0, 32'hDEADBEEF, D2, 3'b010, 0, 1, 31, 32'h0);
        vec[1]  = mk(3'b000, 7, 5, 9, D0, 32'hDEADBEEF, D2, 3'b000, 1, 1, 5, 32'hDEADBEEF);
        vec[2]  = mk(3'b000, 7, 8, 9, D0, D1, D2, 3'b000, 0, 1, 5, 32'hDEADBEEF);
        vec[3]  = mk(3'b100, 7, 8, 0, D0, D1, 32'h12345678, 3'b100, 0, 1, 5, 32'hDEADBEEF);
        vec[4]  = mk(3'b000, 7, 8, 9, D0, D1, D2, 3'b000, 0, 0, 0, 32'h0);
        vec[5]  = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b001, 0, 0, 0, 32'h0);
        vec[6]  = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b010, 1, 1, 7, D0);
        vec[7]  = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b100, 1, 1, 8, D1);
        vec[8]  = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b001, 1, 1, 9, D2);
        vec[9]  = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b010, 1, 1, 7, D0);
        vec[10] = mk(3'b111, 7, 8, 9, D0, D1, D2, 3'b100, 1, 1, 8, D1);
        vec[11] = mk(3'b000, 7, 8, 9, D0, D1, D2, 3'b000, 1, 1, 9, D2);
        vec[12] = mk(3'b000, 7, 8, 9, D0, D1, D2, 3'b000, 0, 1, 9, D2);
        vec[13] = mk(3'b110, 7, 8, 9, D0, D1, D2, 3'b010, 0, 1, 9, D2);
        vec[14] = mk(3'b101, 7, 8, 9, D0, D1, D2, 3'b100, 1, 1, 8, D1);
        vec[15] = mk(3'b001, 7, 8, 9, D0, D1, D2, 3'b001, 1, 1, 9, D2);
        vec[16] = mk(3'b000, 7, 8, 9, D0, D1, D2, 3'b000, 1, 1, 7, D0);

        // Reset state and full clear sequence with idle requesters
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        clear_seq("clear", 40, 3'b000);

        // Arbitration table
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 set_in(vec[i].req, vec[i].a0, vec[i].a1, vec[i].a2, vec[i].d0, vec[i].d1, vec[i].d2);
            @(negedge clk);
            check($sformatf("vec%0d.ack", i), 32'(ack), 32'(vec[i].ack));
            check($sformatf("vec%0d.rf_en", i), 32'(rf_en), 32'(vec[i].en));
            if (vec[i].chk) begin
                check($sformatf("vec%0d.adr", i), 32'(rf_w_adr), 32'(vec[i].adr));
                check($sformatf("vec%0d.data", i), rf_w_data, vec[i].data);
            end
        end

        // Reset with a write sitting in the output register
        @(posedge clk);
        #1 set_in(3'b001, 7, 8, 9, D0, D1, D2);
        @(negedge clk);
        check("pend.ack", 32'(ack), 32'b001);
        @(posedge clk);
        #1;
        check("pend.rf_en", 32'(rf_en), 32'd1);
        check("pend.adr", 32'(rf_w_adr), 32'd7);
        set_in(3'b000, 7, 8, 9, D0, D1, D2);
        rst = 1'b1;
        #1 check_zero("rst_run");

        // req[0] held through INIT, with a reset at the x10 clear write
        set_in(3'b001, 3, 8, 9, 32'h5555AAAA, D1, D2);
        @(negedge clk);
        rst = 1'b0;
        clear_seq("init10", 10, 3'b000);
        rst = 1'b1;
        #1 check_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;
        clear_seq("reclear", 31, 3'b001);
        @(posedge clk);
        #1 set_in(3'b000, 3, 8, 9, 32'h5555AAAA, D1, D2);
        @(negedge clk);
        check("first.rf_en", 32'(rf_en), 32'd1);
        check("first.adr", 32'(rf_w_adr), 32'd3);
        check("first.data", rf_w_data, 32'h5555AAAA);
        check("first.ack", 32'(ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("first.idle_en", 32'(rf_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
